addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
- Multi-cycle, chunk-serial integer add/subtract/compare unit for the RV32I datapath.
- Generalises the combinational subtractor:
  - operand width and per-cycle slice width are parametrised;
  - four operation modes: ADD, SUB, SLT, SLTU;
  - raw carry, signed-overflow and zero flags;
  - valid/ready handshakes on both sides.
- Trades latency for area: one CHUNK_SIZE-bit adder slice is reused over NUM_SIZE/CHUNK_SIZE cycles.

Parameters:
- NUM_SIZE, 32, operand and result width in bits.
- CHUNK_SIZE, 8, bits processed per cycle. Must be >= 1 and divide NUM_SIZE exactly; elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rstN  input  1  asynchronous, active-low reset.
- inValid  input  1  operands and op presented.
- inReady  output  1  unit can accept a request.
- op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
- dIn0  input  NUM_SIZE  first operand / minuend.
- dIn1  input  NUM_SIZE  second operand / subtrahend.
- outValid  output  1  result and flags valid.
- outReady  input  1  consumer accepts the result.
- result  output  NUM_SIZE  sum, difference, or compare bit in bit 0.
- carryOut  output  1  final carry of the raw add; for SUB/SLT/SLTU, 1 means no borrow.
- overflow  output  1  signed overflow of the raw add/sub.
- zero  output  1  raw add/sub result equals 0.

Behaviour:
- Constants and state:
  - NUM_CHUNKS = NUM_SIZE/CHUNK_SIZE.
  - States: IDLE, BUSY, DONE.
  - Chunk counter has width clog2(NUM_CHUNKS), minimum 1.
- Reset (rstN low, asynchronous):
  - state=IDLE, counter=0.
  - result, carryOut, overflow, zero, outValid all 0.
  - Internal operand, carry and op registers cleared.
  - inReady = (state==IDLE) && rstN, so it is 0 while reset is asserted.
- IDLE:
  - inReady=1.
  - On a clk edge with inValid && inReady:
    - latch a=dIn0;
    - latch b=dIn1 for ADD, ~dIn1 for SUB/SLT/SLTU;
    - latch carry=0 for ADD, 1 otherwise;
    - latch op; counter=0; go to BUSY.
- BUSY:
  - inReady=0.
  - Each cycle, slice k=counter computes {c, s} = a[k] + b[k] + carry over CHUNK_SIZE bits.
  - s is written to internal sum bits [k*CHUNK_SIZE +: CHUNK_SIZE]; carry=c; counter increments.
  - On the edge that processes slice NUM_CHUNKS-1:
    - carryOut = final carry.
    - overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the inverted b for subtract modes.
    - zero = (full sum == 0).
    - result:
      - ADD/SUB: full sum.
      - SLT: {0..., sum[MSB] ^ overflow}.
      - SLTU: {0..., ~carryOut}.
    - go to DONE, with outValid=1 from that edge.
  - Latency: outValid rises exactly NUM_CHUNKS clk edges after the accepting edge. CHUNK_SIZE==NUM_SIZE gives latency 1.
- DONE:
  - outValid=1, inReady=0.
  - result and all flags held stable until outReady=1.
  - On the edge with outReady: outValid=0 and go to IDLE. Flags and result keep their value until the next completion.
  - A new request is accepted no earlier than the cycle after the output handshake; minimum initiation interval is NUM_CHUNKS+2 cycles.
- inValid outside IDLE is ignored, with no side effects.
- dIn0/dIn1/op changes after acceptance do not affect the in-flight operation.
- outReady while not in DONE is ignored.
- Reset asserted in any state aborts the operation immediately. No partial outValid is produced. After deassertion the unit is in IDLE.
- Wrap-around: ADD/SUB results are modulo 2^NUM_SIZE; flags report the wrap.

Test Plan:
- NUM_SIZE=32, CHUNK_SIZE=8, ADD 0xFFFFFFFF + 0x00000001 -> outValid exactly 4 edges after accept; result=0x00000000, carryOut=1, overflow=0, zero=1.
- SUB 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, overflow=1, carryOut=1, zero=0. SUB 0x00000000 - 0x00000001 -> result=0xFFFFFFFF, carryOut=0, overflow=0.
- SLT 0xFFFFFFFF vs 0x00000001 -> result=0x00000001. SLTU same operands -> result=0x00000000. SLT 0x7FFFFFFF vs 0x80000000 -> result=0x00000000 (overflow case).
- Backpressure: hold outReady=0 for 5 cycles after outValid while toggling inValid, dIn0, dIn1 and op -> result and flags stable, inReady=0, no second request accepted. outReady=1 -> IDLE next edge, inReady=1.
- Reset mid-BUSY: drop rstN after slice 2 -> all outputs 0 asynchronously. Release -> inReady=1, no outValid until a new request completes correctly.
- Parameter sweep: CHUNK_SIZE in {1,4,32} with 1000 random ops, compared against a reference model -> all results and flags match; latencies are 32, 8 and 1 respectively.

Source files
------------

// File: rtl/addsub_serial.sv
// Chunk-serial add/subtract/compare unit: one CHUNK_SIZE-bit adder slice is reused
// over NUM_SIZE/CHUNK_SIZE cycles, with valid/ready handshakes on both sides.
module addsub_serial #(
  parameter int NUM_SIZE   = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                inValid,
  output logic                inReady,
  input  logic [1:0]          op,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] result,
  output logic                carryOut,
  output logic                overflow,
  output logic                zero
);

  localparam int NUM_CHUNKS = (CHUNK_SIZE >= 1) ? (NUM_SIZE / CHUNK_SIZE) : 1;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int MSB        = NUM_SIZE - 1;

  localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [NUM_SIZE-1:0] CHUNK_MASK = NUM_SIZE'({CHUNK_SIZE{1'b1}});

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  if ((CHUNK_SIZE < 1) || ((NUM_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_chunk
    $error("addsub_serial: CHUNK_SIZE must be >= 1 and divide NUM_SIZE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [NUM_SIZE-1:0] a_r;
  logic [NUM_SIZE-1:0] b_r;
  logic [NUM_SIZE-1:0] sum_r;
  logic                carry_r;
  logic [1:0]          op_r;
  logic [NUM_SIZE-1:0] result_r;
  logic                carry_out_r;
  logic                overflow_r;
  logic                zero_r;
  logic                out_valid_r;

  logic [31:0]           shamt_s;
  logic [CHUNK_SIZE-1:0] a_chunk_s;
  logic [CHUNK_SIZE-1:0] b_chunk_s;
  logic [CHUNK_SIZE:0]   slice_s;
  logic [NUM_SIZE-1:0]   sum_next_s;
  logic                  ovf_s;
  logic                  slt_s;
  logic                  sltu_s;
  logic [NUM_SIZE-1:0]   result_next_s;

  assign inReady  = (state_r == ST_IDLE) && rstN;
  assign outValid = out_valid_r;
  assign result   = result_r;
  assign carryOut = carry_out_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;

  // Slice adder for the current chunk and the merged sum/flags it produces
  always_comb begin
    shamt_s    = 32'(cnt_r) * 32'(CHUNK_SIZE);
    a_chunk_s  = CHUNK_SIZE'(a_r >> shamt_s);
    b_chunk_s  = CHUNK_SIZE'(b_r >> shamt_s);
    slice_s    = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + (CHUNK_SIZE + 1)'(carry_r);
    sum_next_s = (sum_r & ~(CHUNK_MASK << shamt_s))
               | (NUM_SIZE'(slice_s[CHUNK_SIZE-1:0]) << shamt_s);
    // b_r already holds ~dIn1 for subtract modes, so this is the raw-add overflow rule
    ovf_s      = (a_r[MSB] == b_r[MSB]) && (sum_next_s[MSB] != a_r[MSB]);
    slt_s      = sum_next_s[MSB] ^ ovf_s;
    sltu_s     = ~slice_s[CHUNK_SIZE];
    case (op_r)
      OP_ADD:  result_next_s = sum_next_s;
      OP_SUB:  result_next_s = sum_next_s;
      OP_SLT:  result_next_s = NUM_SIZE'(slt_s);
      OP_SLTU: result_next_s = NUM_SIZE'(sltu_s);
      default: result_next_s = sum_next_s;
    endcase
  end

  // Control FSM, operand/accumulator registers and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {NUM_SIZE{1'b0}};
      b_r         <= {NUM_SIZE{1'b0}};
      sum_r       <= {NUM_SIZE{1'b0}};
      carry_r     <= 1'b0;
      op_r        <= 2'b00;
      result_r    <= {NUM_SIZE{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inValid) begin
            a_r     <= dIn0;
            b_r     <= (op == OP_ADD) ? dIn1 : ~dIn1;
            carry_r <= (op != OP_ADD);
            op_r    <= op;
            sum_r   <= {NUM_SIZE{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_s[CHUNK_SIZE];
          if (cnt_r == LAST_CNT) begin
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= result_next_s;
            carry_out_r <= slice_s[CHUNK_SIZE];
            overflow_r  <= ovf_s;
            zero_r      <= (sum_next_s == {NUM_SIZE{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (outReady) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomised checks of addsub_serial at CHUNK_SIZE 8, 1, 4 and 32,
// against hand-computed vectors and an independent arithmetic reference.
module tb_addsub_serial;

  logic        clk;
  logic        rstN;
  logic [1:0]  op;
  logic [31:0] din0;
  logic [31:0] din1;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  carry_o;
  logic [3:0]  ovf_o;
  logic [3:0]  zero_o;
  logic [31:0] res [4];

  int n_checks;
  int n_fail;
  int lat [4];
  int exp_lat [4];

  addsub_serial #(.NUM_SIZE(32), .CHUNK_SIZE(8)) u_c8 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[0]), .inReady(in_ready[0]), .op(op),
    .dIn0(din0), .dIn1(din1), .outValid(out_valid[0]), .outReady(out_ready[0]),
    .result(res[0]), .carryOut(carry_o[0]), .overflow(ovf_o[0]), .zero(zero_o[0]));

  addsub_serial #(.NUM_SIZE(32), .CHUNK_SIZE(1)) u_c1 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[1]), .inReady(in_ready[1]), .op(op),
    .dIn0(din0), .dIn1(din1), .outValid(out_valid[1]), .outReady(out_ready[1]),
    .result(res[1]), .carryOut(carry_o[1]), .overflow(ovf_o[1]), .zero(zero_o[1]));

  addsub_serial #(.NUM_SIZE(32), .CHUNK_SIZE(4)) u_c4 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[2]), .inReady(in_ready[2]), .op(op),
    .dIn0(din0), .dIn1(din1), .outValid(out_valid[2]), .outReady(out_ready[2]),
    .result(res[2]), .carryOut(carry_o[2]), .overflow(ovf_o[2]), .zero(zero_o[2]));

  addsub_serial #(.NUM_SIZE(32), .CHUNK_SIZE(32)) u_c32 (
    .clk(clk), .rstN(rstN), .inValid(in_valid[3]), .inReady(in_ready[3]), .op(op),
    .dIn0(din0), .dIn1(din1), .outValid(out_valid[3]), .outReady(out_ready[3]),
    .result(res[3]), .carryOut(carry_o[3]), .overflow(ovf_o[3]), .zero(zero_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {carry, overflow, zero, result} of one instance
  function automatic logic [63:0] word(input int j);
    return {29'd0, carry_o[j], ovf_o[j], zero_o[j], res[j]};
  endfunction

  // Reference behaviour built from plain integer arithmetic and comparisons
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s33;
    logic [31:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    if (o == 2'b00) begin
      s33 = {1'b0, a} + {1'b0, b};
      s   = s33[31:0];
      c   = s33[32];
      v   = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      s = a - b;
      c = (a >= b);
      v = (a[31] != b[31]) && (s[31] != a[31]);
    end
    case (o)
      2'b10:   r = {31'd0, ($signed(a) < $signed(b))};
      2'b11:   r = {31'd0, (a < b)};
      default: r = s;
    endcase
    return {29'd0, c, v, (s == 32'd0), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] mask, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op       = o;
    din0     = a;
    din1     = b;
    in_valid = mask;
    tick();
    in_valid = 4'b0000;
  endtask

  // Count edges after the accepting edge until each selected outValid rises
  task automatic wait_done(input logic [3:0] mask);
    logic [3:0] seen;
    seen = 4'b0000;
    for (int j = 0; j < 4; j++) lat[j] = 0;
    for (int cyc = 1; (cyc <= 64) && ((seen & mask) != mask); cyc++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (mask[j] && !seen[j] && out_valid[j]) begin
          seen[j] = 1'b1;
          lat[j]  = cyc;
        end
      end
    end
  endtask

  task automatic release_out(input logic [3:0] mask);
    out_ready = mask;
    tick();
    out_ready = 4'b0000;
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    issue(4'b0001, o, a, b);
    wait_done(4'b0001);
    check({tag, "_lat"}, 64'(lat[0]), 64'd4);
    check(tag, word(0), exp);
    release_out(4'b0001);
    check({tag, "_idle"}, {62'd0, out_valid[0], in_ready[0]}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    n_checks   = 0;
    n_fail     = 0;
    exp_lat[0] = 4;
    exp_lat[1] = 32;
    exp_lat[2] = 8;
    exp_lat[3] = 1;
    rstN      = 1'b1;
    op        = 2'b00;
    din0      = 32'd0;
    din1      = 32'd0;
    in_valid  = 4'b0000;
    out_ready = 4'b0000;

    #1 rstN = 1'b0;
    #1;
    check("rst_in_ready", {60'd0, in_ready}, 64'd0);
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("rst_word", word(0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    check("post_rst_in_ready", {60'd0, in_ready}, 64'hF);

    directed("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, {29'd0, 3'b101, 32'h0000_0000});
    directed("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, {29'd0, 3'b110, 32'h7FFF_FFFF});
    directed("sub_brw",  2'b01, 32'h0000_0000, 32'h0000_0001, {29'd0, 3'b000, 32'hFFFF_FFFF});
    directed("slt_neg",  2'b10, 32'hFFFF_FFFF, 32'h0000_0001, {29'd0, 3'b100, 32'h0000_0001});
    directed("sltu_big", 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, {29'd0, 3'b100, 32'h0000_0000});
    directed("slt_ovf",  2'b10, 32'h7FFF_FFFF, 32'h8000_0000, {29'd0, 3'b010, 32'h0000_0000});

    // Backpressure: result must hold while new requests are offered
    issue(4'b0001, 2'b00, 32'd1, 32'd2);
    wait_done(4'b0001);
    check("bp_lat", 64'(lat[0]), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      op          = 2'(i);
      din0        = 32'hDEAD_0000 + 32'(i);
      din1        = 32'h0BAD_F00D ^ 32'(i);
      tick();
      check("bp_word", word(0), {29'd0, 3'b000, 32'h0000_0003});
      check("bp_flags", {62'd0, out_valid[0], in_ready[0]}, 64'd2);
    end
    in_valid[0] = 1'b0;
    release_out(4'b0001);
    check("bp_release", {62'd0, out_valid[0], in_ready[0]}, 64'd1);
    check("bp_hold", word(0), {29'd0, 3'b000, 32'h0000_0003});
    tick();
    check("bp_no_second", {62'd0, out_valid[0], in_ready[0]}, 64'd1);

    // Abort after slice 2, asynchronously between clock edges
    issue(4'b0001, 2'b01, 32'd10, 32'd3);
    tick();
    tick();
    tick();
    #2 rstN = 1'b0;
    #1;
    check("abort_word", word(0), 64'd0);
    check("abort_hs", {62'd0, out_valid[0], in_ready[0]}, 64'd0);
    #2 rstN = 1'b1;
    tick();
    check("abort_in_ready", {63'd0, in_ready[0]}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", {63'd0, out_valid[0]}, 64'd0);
    end
    directed("after_abort", 2'b01, 32'd10, 32'd3, {29'd0, 3'b100, 32'h0000_0007});

    // All four slice widths in parallel against the reference
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'h7FFF_FFFF;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom();
      endcase
      case ($urandom_range(0, 5))
        0:       rb = ra;
        1:       rb = 32'h0000_0001;
        2:       rb = 32'h8000_0000;
        default: rb = $urandom();
      endcase
      issue(4'b1111, ro, ra, rb);
      wait_done(4'b1111);
      for (int j = 0; j < 4; j++) begin
        check("sweep_lat", 64'(lat[j]), 64'(exp_lat[j]));
        check("sweep_word", word(j), model(ro, ra, rb));
      end
      release_out(4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
